// File: rtl/vt100_cursor_engine_pkg.sv
// Shared VT100 pipeline definitions: decoded command set and geometry width helpers.
package VT100Pkg;

    typedef enum logic [3:0] {
        NOP, CUU, CUD, CUF, CUB, CUP, CR, BS,
        HT, LF, RI, NEL, PRINT, DECSTBM, DECSC, DECRC
    } CommandsType;

    function automatic int row_w(input int rows);
        return (rows <= 2) ? 1 : $clog2(rows);
    endfunction

    function automatic int col_w(input int cols);
        return (cols <= 2) ? 1 : $clog2(cols);
    endfunction

endpackage

// File: rtl/vt100_cursor_engine_flatten.sv
// One-stage pipeline turning (row, col) into the linear text-buffer address.
module cursor_pos_flatten #(
    parameter int COLUMNS = 80,
    parameter int ROW_W   = 5,
    parameter int COL_W   = 7
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ROW_W-1:0] row,
    input  logic [COL_W-1:0] col,
    output logic [15:0]      position
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            position <= '0;
        end else begin
            position <= 16'(int'(row) * COLUMNS + int'(col));
        end
    end

endmodule

// File: rtl/vt100_cursor_engine.sv
// Cursor/action engine: margins, deferred wrap, tabs, scroll strobes.
// Optional DECSC/DECRC save registers are built only when CURSOR_SAVE_EN is defined.
module vt100_cursor_engine
    import VT100Pkg::*;
#(
    parameter int COLUMNS   = 80,
    parameter int ROWS      = 24,
    parameter int TAB_WIDTH = 8,
    localparam int ROW_W    = row_w(ROWS),
    localparam int COL_W    = col_w(COLUMNS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             commandReady,
    input  CommandsType      commandType,
    input  logic [7:0]       Pn1,
    input  logic [7:0]       Pn2,
    output logic [ROW_W-1:0] cursorRow,
    output logic [COL_W-1:0] cursorCol,
    output logic [15:0]      cursorPosition,
    output logic             scrollUp,
    output logic             scrollDown,
    output logic             wrapPending
);

    localparam logic [8:0] ROW_MAX = 9'(ROWS - 1);
    localparam logic [8:0] COL_MAX = 9'(COLUMNS - 1);
    localparam logic [8:0] TAB_W   = 9'(TAB_WIDTH);

    logic [ROW_W-1:0] top_m, bot_m;
    logic [8:0] row_ext, col_ext, top_ext, bot_ext;
    logic [8:0] n, p2_one, cup_row, cup_col, stbm_top, stbm_bot, tab_col;
    logic [8:0] lf_row, row_nx, col_nx, top_nx, bot_nx;
    logic       in_region, lf_up, wrap_nx, su_nx, sd_nx;

`ifdef CURSOR_SAVE_EN
    logic [ROW_W-1:0] save_row;
    logic [COL_W-1:0] save_col;
    logic             save_wrap;
`endif

    always_comb begin
        row_ext  = 9'(cursorRow);
        col_ext  = 9'(cursorCol);
        top_ext  = 9'(top_m);
        bot_ext  = 9'(bot_m);
        n        = (Pn1 == 8'd0) ? 9'd1 : {1'b0, Pn1};
        p2_one   = (Pn2 == 8'd0) ? 9'd1 : {1'b0, Pn2};
        cup_row  = (n - 9'd1 > ROW_MAX) ? ROW_MAX : n - 9'd1;
        cup_col  = (p2_one - 9'd1 > COL_MAX) ? COL_MAX : p2_one - 9'd1;
        stbm_top = n - 9'd1;
        stbm_bot = ((Pn2 == 8'd0) ? 9'(ROWS) : {1'b0, Pn2}) - 9'd1;
        tab_col  = (col_ext & ~(TAB_W - 9'd1)) + TAB_W;
        in_region = (row_ext >= top_ext) && (row_ext <= bot_ext);
        // LF at the bottom margin scrolls the region instead of moving
        lf_up    = (row_ext == bot_ext);
        lf_row   = (lf_up || row_ext == ROW_MAX) ? row_ext : row_ext + 9'd1;

        row_nx  = row_ext;
        col_nx  = col_ext;
        top_nx  = top_ext;
        bot_nx  = bot_ext;
        wrap_nx = wrapPending;
        su_nx   = 1'b0;
        sd_nx   = 1'b0;

        if (commandReady) begin
            wrap_nx = 1'b0;
            case (commandType)
                CUU: begin
                    if (in_region)
                        row_nx = (n > row_ext - top_ext) ? top_ext : row_ext - n;
                    else
                        row_nx = (n > row_ext) ? 9'd0 : row_ext - n;
                end
                CUD: begin
                    if (in_region)
                        row_nx = (row_ext + n > bot_ext) ? bot_ext : row_ext + n;
                    else
                        row_nx = (row_ext + n > ROW_MAX) ? ROW_MAX : row_ext + n;
                end
                CUF: col_nx = (col_ext + n > COL_MAX) ? COL_MAX : col_ext + n;
                CUB: col_nx = (n > col_ext) ? 9'd0 : col_ext - n;
                CUP: begin
                    row_nx = cup_row;
                    col_nx = cup_col;
                end
                CR:  col_nx = 9'd0;
                BS:  col_nx = (col_ext == 9'd0) ? 9'd0 : col_ext - 9'd1;
                HT:  col_nx = (tab_col > COL_MAX) ? COL_MAX : tab_col;
                LF: begin
                    row_nx = lf_row;
                    su_nx  = lf_up;
                end
                RI: begin
                    if (row_ext == top_ext) sd_nx = 1'b1;
                    else row_nx = (row_ext == 9'd0) ? 9'd0 : row_ext - 9'd1;
                end
                NEL: begin
                    row_nx = lf_row;
                    su_nx  = lf_up;
                    col_nx = 9'd0;
                end
                PRINT: begin
                    // the pending glyph lands in column 0 of the next line
                    if (wrapPending) begin
                        row_nx = lf_row;
                        su_nx  = lf_up;
                        col_nx = 9'd1;
                    end else if (col_ext == COL_MAX) begin
                        wrap_nx = 1'b1;
                    end else begin
                        col_nx = col_ext + 9'd1;
                    end
                end
                DECSTBM: begin
                    if (stbm_top < stbm_bot && stbm_bot <= ROW_MAX) begin
                        top_nx = stbm_top;
                        bot_nx = stbm_bot;
                        row_nx = 9'd0;
                        col_nx = 9'd0;
                    end
                end
`ifdef CURSOR_SAVE_EN
                DECRC: begin
                    row_nx  = 9'(save_row);
                    col_nx  = 9'(save_col);
                    wrap_nx = save_wrap;
                end
`endif
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cursorRow   <= '0;
            cursorCol   <= '0;
            wrapPending <= 1'b0;
            scrollUp    <= 1'b0;
            scrollDown  <= 1'b0;
            top_m       <= '0;
            bot_m       <= ROW_W'(ROWS - 1);
        end else begin
            cursorRow   <= ROW_W'(row_nx);
            cursorCol   <= COL_W'(col_nx);
            wrapPending <= wrap_nx;
            scrollUp    <= su_nx;
            scrollDown  <= sd_nx;
            top_m       <= ROW_W'(top_nx);
            bot_m       <= ROW_W'(bot_nx);
        end
    end

`ifdef CURSOR_SAVE_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            save_row  <= '0;
            save_col  <= '0;
            save_wrap <= 1'b0;
        end else if (commandReady && commandType == DECSC) begin
            save_row  <= cursorRow;
            save_col  <= cursorCol;
            save_wrap <= wrapPending;
        end
    end
`endif

    cursor_pos_flatten #(
        .COLUMNS (COLUMNS),
        .ROW_W   (ROW_W),
        .COL_W   (COL_W)
    ) u_flatten (
        .clk      (clk),
        .rst      (rst),
        .row      (cursorRow),
        .col      (cursorCol),
        .position (cursorPosition)
    );

endmodule
